// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store initiator between the CPU pipeline and a byte-addressed,
// big-endian DataMemory with a single 32-bit word port.
//   - Byte, halfword and word loads, each sign- or zero-extended.
//   - Word stores write directly.
//   - Sub-word stores do a read-modify-write, because the memory always
//     writes all 4 bytes.
//   - Misaligned and illegal-size accesses fault with no memory write.
//
// Optional feature macro: MAU_RANGE_CHECK_EN
//   When defined, an access whose word base lies beyond the last word
//   (MEMORY_SIZE-4) also faults. When undefined, such accesses run normally:
//   the memory returns 0 on reads and ignores writes.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE. The response is
// a single-cycle resp_valid pulse; there is no response back-pressure.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  request handshake
//   req_write            1 = store, 0 = load
//   req_size             00 byte, 01 half, 10 word, 11 illegal
//   req_signed           load extension select
//   req_addr             byte address
//   req_wdata            right-aligned store data
//   resp_valid           one-cycle response pulse
//   resp_rdata           load result (0 for stores and faults)
//   resp_fault           access faulted, memory untouched
//   mem_addr             word-aligned address to DataMemory
//   mem_wdata            merged word to DataMemory
//   mem_write            one-cycle write strobe
//   mem_rdata            combinational DataMemory read word
//   dbg_state_o          current FSM state, for observation only
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int MEMORY_SIZE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state_o
);

    if ((MEMORY_SIZE < 4) || ((MEMORY_SIZE % 4) != 0)) begin : g_bad_memory_size
        $error("mem_access_unit: MEMORY_SIZE must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t      state_q;
    logic [31:0] addr_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [15:0] wdata_q;      // only the sub-word lanes are needed for merging
    logic [31:0] word_q;       // word presented on mem_wdata
    logic        resp_valid_q;
    logic        resp_fault_q;
    logic [31:0] resp_rdata_q;
    logic        mem_write_q;

    logic        req_fault_d;
    logic        range_fault_d;
    logic [31:0] load_data_d;
    logic [31:0] merge_data_d;

    // Extract the addressed lane(s) from a big-endian word and extend.
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (size)
            SIZE_BYTE: r = {{24{sgn & b[7]}}, b};
            SIZE_HALF: r = {{16{sgn & h[15]}}, h};
            default:   r = w;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane(s); every other byte passes through.
    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic [15:0] d,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = w;
        if (size == SIZE_BYTE) begin
            case (off)
                2'd0:    r[31:24] = d[7:0];
                2'd1:    r[23:16] = d[7:0];
                2'd2:    r[15:8]  = d[7:0];
                default: r[7:0]   = d[7:0];
            endcase
        end else begin
            if (off[1]) r[15:0]  = d;
            else        r[31:16] = d;
        end
        return r;
    endfunction

`ifdef MAU_RANGE_CHECK_EN
    localparam logic [31:0] LAST_WORD = 32'(MEMORY_SIZE - 4);
    assign range_fault_d = ({req_addr[31:2], 2'b00} > LAST_WORD);
`else
    assign range_fault_d = 1'b0;
`endif

    assign req_fault_d = (req_size == 2'b11)
                       || ((req_size == SIZE_HALF) && req_addr[0])
                       || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
                       || range_fault_d;

    assign load_data_d  = load_extract(mem_rdata, size_q, addr_q[1:0], signed_q);
    assign merge_data_d = store_merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= 32'h0;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            wdata_q      <= 16'h0;
            word_q       <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_write_q  <= 1'b0;
        end else begin
            // Both strobes are single-cycle pulses unless re-armed below.
            resp_valid_q <= 1'b0;
            mem_write_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        write_q  <= req_write;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        wdata_q  <= req_wdata[15:0];
                        word_q   <= req_wdata;
                        if (req_fault_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else if (req_write && (req_size == SIZE_WORD)) begin
                            state_q     <= WRITE;
                            mem_write_q <= 1'b1;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (write_q) begin
                        word_q      <= merge_data_d;
                        state_q     <= WRITE;
                        mem_write_q <= 1'b1;
                    end else begin
                        resp_rdata_q <= load_data_d;
                        resp_fault_q <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                WRITE: begin
                    resp_rdata_q <= 32'h0;
                    resp_fault_q <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_fault  = resp_fault_q;
    assign mem_addr    = {addr_q[31:2], 2'b00};
    assign mem_wdata   = word_q;
    assign mem_write   = mem_write_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Drives mem_access_unit against a 16-byte big-endian DataMemory model that is
// preloaded with bytes 0x00..0x0F. A separate byte-array reference model
// predicts every response (data, fault, latency, number of write strobes).
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int MEM_BYTES = 16;

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // ------------------------------------------------------------ DUT
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    mem_access_unit #(.MEMORY_SIZE(MEM_BYTES)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_fault  (resp_fault),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata),
        .dbg_state_o (dbg_state)
    );

    // ------------------------------------------------------------ DataMemory
    logic [7:0] dm [MEM_BYTES];

    always_comb begin
        mem_rdata = 32'h0;
        if (mem_addr <= 32'(MEM_BYTES - 4))
            mem_rdata = {dm[mem_addr], dm[mem_addr + 1], dm[mem_addr + 2], dm[mem_addr + 3]};
    end

    always @(posedge clk) begin
        if (mem_write && (mem_addr <= 32'(MEM_BYTES - 4))) begin
            dm[mem_addr]     <= mem_wdata[31:24];
            dm[mem_addr + 1] <= mem_wdata[23:16];
            dm[mem_addr + 2] <= mem_wdata[15:8];
            dm[mem_addr + 3] <= mem_wdata[7:0];
        end
    end

    // ------------------------------------------------------------ checking
    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endfunction

    // ------------------------------------------------------------ reference model
    logic [7:0] model_mem [MEM_BYTES];

    logic [31:0] exp_q       [$];
    int          exp_fault_q [$];
    int          exp_lat_q   [$];
    int          exp_nw_q    [$];

    // Predicts one access from the rules, then commits any store into model_mem.
    function automatic void model_push(input logic w, input logic [1:0] sz, input logic sg,
                                       input logic [31:0] a, input logic [31:0] wd);
        int          base;
        int          off;
        logic [31:0] word;
        logic [31:0] val;
        logic        fault;
        base  = int'(a & 32'hFFFF_FFFC);
        off   = int'(a % 4);
        fault = (sz == 2'b11) || (sz == 2'b01 && (off % 2) == 1) || (sz == 2'b10 && off != 0);
`ifdef MAU_RANGE_CHECK_EN
        if (a > 32'(MEM_BYTES - 1)) fault = 1'b1;
`endif
        if (fault) begin
            exp_q.push_back(32'h0); exp_fault_q.push_back(1);
            exp_lat_q.push_back(1); exp_nw_q.push_back(0);
            return;
        end
        if (!w) begin
            word = 32'h0;
            if (a <= 32'(MEM_BYTES - 1))
                word = {model_mem[base], model_mem[base + 1], model_mem[base + 2], model_mem[base + 3]};
            if (sz == 2'b00) begin
                val = (word >> (8 * (3 - off))) & 32'hFF;
                if (sg && val >= 32'h80) val = val | 32'hFFFF_FF00;
            end else if (sz == 2'b01) begin
                val = (word >> (8 * (2 - off))) & 32'hFFFF;
                if (sg && val >= 32'h8000) val = val | 32'hFFFF_0000;
            end else begin
                val = word;
            end
            exp_q.push_back(val); exp_fault_q.push_back(0);
            exp_lat_q.push_back(2); exp_nw_q.push_back(0);
        end else begin
            exp_q.push_back(32'h0); exp_fault_q.push_back(0);
            exp_lat_q.push_back(sz == 2'b10 ? 2 : 3); exp_nw_q.push_back(1);
            if (a <= 32'(MEM_BYTES - 1)) begin
                if (sz == 2'b00) begin
                    model_mem[a] = wd[7:0];
                end else if (sz == 2'b01) begin
                    model_mem[a]     = wd[15:8];
                    model_mem[a + 1] = wd[7:0];
                end else begin
                    model_mem[a]     = wd[31:24];
                    model_mem[a + 1] = wd[23:16];
                    model_mem[a + 2] = wd[15:8];
                    model_mem[a + 3] = wd[7:0];
                end
            end
        end
    endfunction

    // ------------------------------------------------------------ compare process
    int          acc_cycle  = 0;
    int          resp_count = 0;
    int          wr_cnt     = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_fault = 1'b0;
    int          last_lat   = 0;
    int          last_nw    = 0;

    always @(negedge clk) begin
        if (rst) begin
            wr_cnt = 0;
        end else begin
            if (mem_write) wr_cnt++;
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    last_lat = cycle - acc_cycle + 1;
                    last_nw  = wr_cnt;
                    check("resp_rdata",   resp_rdata,       exp_q.pop_front());
                    check("resp_fault",   32'(resp_fault),  32'(exp_fault_q.pop_front()));
                    check("resp_latency", 32'(last_lat),    32'(exp_lat_q.pop_front()));
                    check("write_count",  32'(last_nw),     32'(exp_nw_q.pop_front()));
                    check("ready_in_resp", 32'(req_ready),  32'd0);
                end
                last_rdata = resp_rdata;
                last_fault = resp_fault;
                wr_cnt     = 0;
                resp_count++;
            end
        end
    end

    // ------------------------------------------------------------ driver
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
        int n;
        int waited;
        n = resp_count;
        @(negedge clk);
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        model_push(w, sz, sg, a, wd);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        acc_cycle  = cycle + 1;
        @(negedge clk);
        // Junk on the request bus must be ignored once the access is in flight.
        req_valid  = 1'b0;
        req_write  = 1'($urandom_range(0, 1));
        req_size   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        waited = 0;
        while (resp_count == n && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (resp_count == n) begin
            check("resp_timeout", 32'd0, 32'd1);
            exp_q.delete(); exp_fault_q.delete(); exp_lat_q.delete(); exp_nw_q.delete();
        end
    endtask

    // ------------------------------------------------------------ main sequence
    initial begin
        int n0;
        logic abandoned_write;
        for (int i = 0; i < MEM_BYTES; i++) begin
            dm[i]        = 8'(i);
            model_mem[i] = 8'(i);
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata,      32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);
        check("rst_mem_write",  32'(mem_write),  32'd0);
        check("rst_mem_addr",   mem_addr,        32'd0);
        check("rst_mem_wdata",  mem_wdata,       32'd0);
        rst = 1'b0;

        // Literal expectations pinning the model.
        do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
        check("lit_word_load4", last_rdata, 32'h0405_0607);
        check("lit_word_load4_lat", 32'(last_lat), 32'd2);
        check("lit_word_load4_nw", 32'(last_nw), 32'd0);

        do_req(1'b0, 2'b00, 1'b1, 32'd15, 32'h0);
        check("lit_byte15_signed", last_rdata, 32'h0000_000F);

        do_req(1'b1, 2'b00, 1'b0, 32'd15, 32'h1234_5680);
        do_req(1'b0, 2'b00, 1'b1, 32'd15, 32'h0);
        check("lit_byte15_s80", last_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 2'b00, 1'b0, 32'd15, 32'h0);
        check("lit_byte15_u80", last_rdata, 32'h0000_0080);

        do_req(1'b1, 2'b01, 1'b0, 32'd2, 32'hCAFE_BEEF);
        check("lit_half_store_lat", 32'(last_lat), 32'd3);
        check("lit_half_store_nw", 32'(last_nw), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'h0);
        check("lit_word_load0", last_rdata, 32'h0001_BEEF);

        do_req(1'b0, 2'b01, 1'b0, 32'd3, 32'h0);
        check("lit_half3_fault", 32'(last_fault), 32'd1);
        check("lit_half3_lat", 32'(last_lat), 32'd1);
        do_req(1'b1, 2'b10, 1'b0, 32'd6, 32'hDEAD_BEEF);
        check("lit_word6_fault", 32'(last_fault), 32'd1);
        check("lit_word6_nw", 32'(last_nw), 32'd0);
        do_req(1'b0, 2'b11, 1'b0, 32'd8, 32'h0);
        check("lit_size3_fault", 32'(last_fault), 32'd1);

        do_req(1'b0, 2'b10, 1'b0, 32'd16, 32'h0);
`ifdef MAU_RANGE_CHECK_EN
        check("lit_word16_fault", 32'(last_fault), 32'd1);
`else
        check("lit_word16_fault", 32'(last_fault), 32'd0);
        check("lit_word16_rdata", last_rdata, 32'h0);
`endif

        // Reset while a byte store sits in READ: abandoned, no write, no response.
        @(negedge clk);
        n0 = resp_count;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'h0000_00AA;
        @(negedge clk);
        req_valid = 1'b0;
        check("abandon_in_read", 32'(dbg_state), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        abandoned_write = mem_write;
        check("abandon_ready", 32'(req_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            abandoned_write = abandoned_write | mem_write;
        end
        check("abandon_no_write", 32'(abandoned_write), 32'd0);
        check("abandon_no_resp", 32'(resp_count), 32'(n0));
        do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'h0);
        check("abandon_mem_intact", last_rdata, 32'h0001_BEEF);

        // Randomized traffic, including out-of-range addresses 16..19.
        for (int i = 0; i < 200; i++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 19)), $urandom);
        end

        // Final sweep of every word against the model.
        for (int a = 0; a < MEM_BYTES; a += 4)
            do_req(1'b0, 2'b10, 1'b0, 32'(a), 32'h0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1, required 0");
        $fatal(1, "timeout");
    end

endmodule
